// File: rtl/calc_uart_tx.sv
// Calculator result transmitter: captures a/op/b on a rising en_tx, computes an 8-bit result, sends it as a UART frame.
// Optional build macro CALC_ASCII_EN sends the result as two ASCII hex characters instead of one raw byte.
module calc_uart_tx #(
  parameter int OVS        = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en_tx,
  input  logic [3:0] a,
  input  logic [3:0] op,
  input  logic [3:0] b,
  output logic       dout,
  output logic       busy,
  output logic       done,
  output logic [7:0] result
);

  localparam int CMAX = (OVS > STOP_TICKS) ? OVS : STOP_TICKS;
  localparam int SW   = $clog2(CMAX + 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, CALC, START, DATA, STOP, DONE} state_t;

  state_t        state;
  logic          en_d;
  logic [3:0]    a_q, op_q, b_q;
  logic [7:0]    shreg;
  logic [SW-1:0] s;
  logic [2:0]    n;
  logic [7:0]    calc_val;
  logic          trigger;

  function automatic logic [7:0] alu(input logic [3:0] x, input logic [3:0] o, input logic [3:0] y);
    logic [7:0] xe, ye;
    xe = {4'h0, x};
    ye = {4'h0, y};
    case (o)
      4'd0:    return xe + ye;
      4'd1:    return xe - ye;
      4'd2:    return xe * ye;
      4'd3:    return xe & ye;
      4'd4:    return xe | ye;
      4'd5:    return xe ^ ye;
      default: return 8'hFF;
    endcase
  endfunction

`ifdef CALC_ASCII_EN
  logic [7:0] lo_char;
  logic       second;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  endfunction
`endif

  assign calc_val = alu(a_q, op_q, b_q);
  assign trigger  = en_tx & ~en_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      en_d   <= 1'b0;
      dout   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 8'h00;
      a_q    <= 4'h0;
      op_q   <= 4'h0;
      b_q    <= 4'h0;
      shreg  <= 8'h00;
      s      <= '0;
      n      <= 3'd0;
`ifdef CALC_ASCII_EN
      lo_char <= 8'h00;
      second  <= 1'b0;
`endif
    end else begin
      en_d <= en_tx;
      case (state)
        IDLE: if (trigger) begin
          a_q   <= a;
          op_q  <= op;
          b_q   <= b;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          result <= calc_val;
`ifdef CALC_ASCII_EN
          shreg   <= hex_char(calc_val[7:4]);
          lo_char <= hex_char(calc_val[3:0]);
          second  <= 1'b0;
`else
          shreg   <= calc_val;
`endif
          s     <= '0;
          n     <= 3'd0;
          dout  <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          if (s == S_BIT) begin
            s     <= '0;
            dout  <= shreg[0];
            state <= DATA;
          end else s <= s + 1'b1;
        end
        // dout is registered, so the next data bit is presented on the boundary tick itself
        DATA: if (tick) begin
          if (s == S_BIT) begin
            s <= '0;
            if (n == 3'd7) begin
              dout  <= 1'b1;
              state <= STOP;
            end else begin
              shreg <= {1'b0, shreg[7:1]};
              dout  <= shreg[1];
              n     <= n + 3'd1;
            end
          end else s <= s + 1'b1;
        end
        STOP: if (tick) begin
          if (s == S_STOP) begin
            s <= '0;
`ifdef CALC_ASCII_EN
            if (!second) begin
              second <= 1'b1;
              shreg  <= lo_char;
              n      <= 3'd0;
              dout   <= 1'b0;
              state  <= START;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end else s <= s + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_uart_tx.sv
// Randomized self-checking bench for calc_uart_tx: line is sampled on every tick and compared to an ideal frame model.
module tb_calc_uart_tx;
  localparam int OVS        = 16;
  localparam int STOP_TICKS = 16;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, en_tx = 1'b0;
  logic [3:0] a = 4'h0, op = 4'h0, b = 4'h0;
  logic       dout, busy, done;
  logic [7:0] result;

  int checks = 0, errors = 0;
  bit tick_en = 1'b1;
  bit rec = 1'b0;
  bit got[$];
  bit exp_q[$];

  calc_uart_tx #(.OVS(OVS), .STOP_TICKS(STOP_TICKS)) dut (
    .clk(clk), .rst(rst), .tick(tick), .en_tx(en_tx),
    .a(a), .op(op), .b(b),
    .dout(dout), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Baud strobe with random spacing of 1..3 idle cycles between ticks
  initial begin : tickgen
    int gap;
    gap = 0;
    forever begin
      @(posedge clk); #1;
      if (tick_en && gap == 0) begin
        tick = 1'b1;
        gap  = $urandom_range(1, 3);
      end else begin
        tick = 1'b0;
        if (gap > 0) gap--;
      end
    end
  end

  // Line sampler: one sample per tick from the first low tick until done
  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst) rec = 1'b0;
      else if (rec && done) rec = 1'b0;
      else if (tick && busy && (rec || dout == 1'b0)) begin
        if (!rec) begin
          got.delete();
          rec = 1'b1;
        end
        got.push_back(dout);
      end
    end
  end

  function automatic logic [7:0] model(input int x, input int o, input int y);
    case (o)
      0:       return 8'((x + y) % 256);
      1:       return 8'((x - y + 256) % 256);
      2:       return 8'((x * y) % 256);
      3:       return 8'(x & y);
      4:       return 8'(x | y);
      5:       return 8'(x ^ y);
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] asc(input int nib);
    return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
  endfunction

  task automatic push_char(input logic [7:0] c);
    repeat (OVS) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (OVS) exp_q.push_back(c[i]);
    repeat (STOP_TICKS) exp_q.push_back(1'b1);
  endtask

  task automatic build_exp(input logic [7:0] r);
    exp_q.delete();
`ifdef CALC_ASCII_EN
    push_char(asc(r / 8'd16));
    push_char(asc(r % 8'd16));
`else
    push_char(r);
`endif
  endtask

  // -1 when the sampled line equals the model, otherwise first differing sample index
  function automatic int frame_diff();
    int m;
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got[i] != exp_q[i]) return i;
    if (got.size() != exp_q.size()) return m;
    return -1;
  endfunction

  // Drives a rising en_tx and returns just after the trigger (capture) edge
  task automatic start_txn(input logic [3:0] x, input logic [3:0] o, input logic [3:0] y);
    @(posedge clk); #1;
    en_tx = 1'b0;
    @(posedge clk); #1;
    got.delete();
    a = x; op = o; b = y;
    en_tx = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_done(output bit ok, output bit busy_ok);
    ok = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit ok, bok;
    int d;
    rst = 1'b0; en_tx = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dout !== 1'b1)     begin errors++; $display("FAIL reset_dout got %b exp 1", dout); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== 8'h00)  begin errors++; $display("FAIL reset_result got %h exp 00", result); end
    // en_tx already high when reset lifts must still trigger
    a = 4'h5; op = 4'h3; b = 4'hC; en_tx = 1'b1;
    @(posedge clk); #1;
    got.delete();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_trigger_busy got %b exp 1", busy); end
    build_exp(model(5, 3, 12));
    wait_done(ok, bok);
    checks++; if (!ok) begin errors++; $display("FAIL release_trigger_done timeout got 0 exp 1"); end
    checks++; if (result !== model(5, 3, 12)) begin errors++; $display("FAIL release_trigger_result got %h exp %h", result, model(5, 3, 12)); end
    d = frame_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL release_trigger_frame idx %0d got len %0d exp len %0d", d, got.size(), exp_q.size()); end
  endtask

  task automatic test_add();
    bit ok, bok;
    int d;
    build_exp(8'h10);
    start_txn(4'h7, 4'h0, 4'h9);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || dout !== 1'b1) begin errors++; $display("FAIL add_capture got busy %b dout %b exp 1 1", busy, dout); end
    @(negedge clk);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL add_start_latency got dout %b exp 0", dout); end
    wait_done(ok, bok);
    checks++; if (!ok)  begin errors++; $display("FAIL add_done timeout got 0 exp 1"); end
    checks++; if (!bok) begin errors++; $display("FAIL add_busy_gap got 0 exp 1"); end
    checks++; if (result !== 8'h10) begin errors++; $display("FAIL add_result got %h exp 10", result); end
    d = frame_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL add_frame idx %0d got len %0d exp len %0d", d, got.size(), exp_q.size()); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done_pulse got done %b busy %b exp 0 0", done, busy); end
  endtask

  task automatic test_ops();
    logic [3:0] ta[3] = '{4'd3, 4'd15, 4'd4};
    logic [3:0] to[3] = '{4'd1, 4'd2,  4'd9};
    logic [3:0] tb[3] = '{4'd5, 4'd15, 4'd2};
    logic [7:0] te[3] = '{8'hFE, 8'hE1, 8'hFF};
    logic [3:0] x, o, y;
    logic [7:0] e;
    bit ok, bok;
    int d;
    for (int k = 0; k < 9; k++) begin
      if (k < 3) begin
        x = ta[k]; o = to[k]; y = tb[k]; e = te[k];
      end else begin
        x = 4'($urandom_range(0, 15));
        o = 4'($urandom_range(0, 15));
        y = 4'($urandom_range(0, 15));
        e = model(int'(x), int'(o), int'(y));
      end
      build_exp(e);
      start_txn(x, o, y);
      wait_done(ok, bok);
      checks++; if (!ok)  begin errors++; $display("FAIL op%0d_done timeout got 0 exp 1", k); end
      checks++; if (!bok) begin errors++; $display("FAIL op%0d_busy_gap got 0 exp 1", k); end
      checks++; if (result !== e) begin errors++; $display("FAIL op%0d_result a %h op %h b %h got %h exp %h", k, x, o, y, result, e); end
      d = frame_diff();
      checks++; if (d != -1) begin errors++; $display("FAIL op%0d_frame idx %0d got len %0d exp len %0d", k, d, got.size(), exp_q.size()); end
    end
  endtask

  task automatic test_retrigger();
    bit ok, bok, spur;
    int d;
    logic [7:0] e1, e2;
    e1 = model(6, 4, 9);
    e2 = model(2, 5, 7);
    build_exp(e1);
    start_txn(4'h6, 4'h4, 4'h9);
    for (int i = 0; i < 4000 && got.size() < 40; i++) @(negedge clk);
    @(posedge clk); #1; en_tx = 1'b0; a = 4'h1; op = 4'h0; b = 4'h1;
    @(posedge clk); #1; en_tx = 1'b1;
    @(posedge clk); #1; en_tx = 1'b0;
    @(posedge clk); #1; en_tx = 1'b1;
    @(negedge clk);
    checks++; if (result !== e1) begin errors++; $display("FAIL retrig_result_held got %h exp %h", result, e1); end
    wait_done(ok, bok);
    checks++; if (!ok || !bok) begin errors++; $display("FAIL retrig_done got ok %b busy_ok %b exp 1 1", ok, bok); end
    d = frame_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL retrig_frame idx %0d got len %0d exp len %0d", d, got.size(), exp_q.size()); end
    spur = 1'b0;
    @(negedge clk);
    repeat (60) begin @(negedge clk); if (busy) spur = 1'b1; end
    checks++; if (spur) begin errors++; $display("FAIL retrig_no_second_frame got busy 1 exp 0"); end
    build_exp(e2);
    start_txn(4'h2, 4'h5, 4'h7);
    wait_done(ok, bok);
    checks++; if (result !== e2) begin errors++; $display("FAIL retrig_next_result got %h exp %h", result, e2); end
    d = frame_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL retrig_next_frame idx %0d got len %0d exp len %0d", d, got.size(), exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    bit reached, bad;
    start_txn(4'h9, 4'h2, 4'h7);
    reached = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (got.size() >= OVS + 3 * OVS + OVS / 2) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach_bit3 timeout got %0d samples", got.size()); end
    @(posedge clk); #1;
    rst = 1'b0; en_tx = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (dout !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got dout %b busy %b done %b exp 1 0 0", dout, busy, done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid_result got %h exp 00", result); end
    @(posedge clk); #1; rst = 1'b1;
    bad = 1'b0;
    repeat (300) begin @(negedge clk); if (busy !== 1'b0 || dout !== 1'b1) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL rstmid_idle_after got activity exp idle line"); end
  endtask

  task automatic test_tick_gating();
    bit ok, bok, low, bad;
    int d;
    logic [7:0] e;
    e = model(10, 5, 3);
    build_exp(e);
    start_txn(4'hA, 4'h5, 4'h3);
    low = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (dout == 1'b0) begin low = 1'b1; break; end end
    checks++; if (!low) begin errors++; $display("FAIL gate_start_seen got dout %b exp 0", dout); end
    @(posedge clk); #1; tick_en = 1'b0;
    bad = 1'b0;
    repeat (1000) begin @(negedge clk); if (dout !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL gate_hold_start got dout 1 exp 0"); end
    tick_en = 1'b1;
    wait_done(ok, bok);
    checks++; if (!ok || !bok) begin errors++; $display("FAIL gate_done got ok %b busy_ok %b exp 1 1", ok, bok); end
    checks++; if (result !== e) begin errors++; $display("FAIL gate_result got %h exp %h", result, e); end
    d = frame_diff();
    checks++; if (d != -1) begin errors++; $display("FAIL gate_frame idx %0d got len %0d exp len %0d", d, got.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_retrigger();
    test_reset_midframe();
    test_tick_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
